// File: rtl/div_ctrl.sv
// div_ctrl: multi-cycle 32-bit restoring divider (signed/unsigned) for the EX stage.
// Macro DIV_ZERO_FAST_EN: zero divisors bypass the iteration through a BYZERO state.
`ifndef RstEnable
`define RstEnable 1'b1
`endif

module div_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        busy_o
);

`ifdef DIV_ZERO_FAST_EN
  typedef enum logic [1:0] {FREE = 2'd0, ON = 2'd1, END = 2'd2, BYZERO = 2'd3} state_e;
`else
  typedef enum logic [1:0] {FREE = 2'd0, ON = 2'd1, END = 2'd2} state_e;
`endif

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [64:0] sr_q, sr_d;
  logic [31:0] divisor_q, divisor_d;
  logic        signed_q, signed_d;
  logic        neg1_q, neg1_d;
  logic        neg2_q, neg2_d;
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;

  logic [33:0] cand_s;
  logic [33:0] trial_s;
  logic [31:0] quot_fix_s;
  logic [31:0] rem_fix_s;

  function automatic logic [31:0] mag_f(input logic sgn, input logic [31:0] v);
    return (sgn && v[31]) ? (32'd0 - v) : v;
  endfunction

  // Shift the partial remainder left by one, pulling in the next dividend bit;
  // bit 33 of the trial difference is the borrow.
  assign cand_s     = sr_q[64:31];
  assign trial_s    = cand_s - {2'b00, divisor_q};
  assign quot_fix_s = (signed_q && (neg1_q ^ neg2_q)) ? (32'd0 - sr_q[31:0]) : sr_q[31:0];
  assign rem_fix_s  = (signed_q && neg1_q) ? (32'd0 - sr_q[63:32]) : sr_q[63:32];

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    divisor_d = divisor_q;
    signed_d  = signed_q;
    neg1_d    = neg1_q;
    neg2_d    = neg2_q;
    result_d  = result_q;
    ready_d   = ready_q;
    case (state_q)
      FREE: begin
        if (start_i && !annul_i) begin
          cnt_d     = 6'd0;
          sr_d      = {33'd0, mag_f(signed_div_i, opdata1_i)};
          divisor_d = mag_f(signed_div_i, opdata2_i);
          signed_d  = signed_div_i;
          neg1_d    = signed_div_i & opdata1_i[31];
          neg2_d    = signed_div_i & opdata2_i[31];
`ifdef DIV_ZERO_FAST_EN
          state_d   = (opdata2_i == 32'd0) ? BYZERO : ON;
`else
          state_d   = ON;
`endif
        end else begin
          state_d  = FREE;
          ready_d  = 1'b0;
          result_d = 64'd0;
        end
      end
      ON: begin
        if (annul_i) begin
          state_d  = FREE;
          ready_d  = 1'b0;
          result_d = 64'd0;
        end else if (cnt_q == 6'd32) begin
          state_d  = END;
          ready_d  = 1'b1;
          result_d = {rem_fix_s, quot_fix_s};
        end else begin
          sr_d  = trial_s[33] ? {cand_s[32:0], sr_q[30:0], 1'b0}
                              : {trial_s[32:0], sr_q[30:0], 1'b1};
          cnt_d = cnt_q + 6'd1;
        end
      end
`ifdef DIV_ZERO_FAST_EN
      // One dwell cycle so the result appears two edges after the start.
      BYZERO: begin
        if (annul_i) begin
          state_d  = FREE;
          ready_d  = 1'b0;
          result_d = 64'd0;
        end else if (cnt_q == 6'd0) begin
          cnt_d = 6'd1;
        end else begin
          state_d  = END;
          ready_d  = 1'b1;
          result_d = 64'd0;
        end
      end
`endif
      END: begin
        if (!start_i) begin
          state_d  = FREE;
          ready_d  = 1'b0;
          result_d = 64'd0;
        end else begin
          state_d = END;
        end
      end
      default: begin
        state_d  = FREE;
        ready_d  = 1'b0;
        result_d = 64'd0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst == `RstEnable) begin
      state_q   <= FREE;
      cnt_q     <= 6'd0;
      sr_q      <= 65'd0;
      divisor_q <= 32'd0;
      signed_q  <= 1'b0;
      neg1_q    <= 1'b0;
      neg2_q    <= 1'b0;
      result_q  <= 64'd0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      divisor_q <= divisor_d;
      signed_q  <= signed_d;
      neg1_q    <= neg1_d;
      neg2_q    <= neg2_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;
  assign busy_o   = (state_q != FREE);

endmodule

// File: tb/tb_div_ctrl.sv
// Directed and randomized bench for div_ctrl against an arithmetic reference model.
module tb_div_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        signed_div = 1'b0;
  logic [31:0] op1 = 32'd0;
  logic [31:0] op2 = 32'd0;
  logic        start = 1'b0;
  logic        annul = 1'b0;
  logic [63:0] result;
  logic        ready;
  logic        busy;

  int n_pass  = 0;
  int n_total = 0;

  div_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .signed_div_i(signed_div),
    .opdata1_i   (op1),
    .opdata2_i   (op2),
    .start_i     (start),
    .annul_i     (annul),
    .result_o    (result),
    .ready_o     (ready),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: quotient/remainder from plain arithmetic on magnitudes.
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb, q, r;
    logic na, nb;
    na = sgn && a[31];
    nb = sgn && b[31];
    ma = na ? (32'd0 - a) : a;
    mb = nb ? (32'd0 - b) : b;
    if (b == 32'd0) begin
`ifdef DIV_ZERO_FAST_EN
      return 64'd0;
`else
      q = 32'hFFFF_FFFF;
      r = ma;
`endif
    end else begin
      q = ma / mb;
      r = ma % mb;
    end
    if (na != nb) q = 32'd0 - q;
    if (na) r = 32'd0 - r;
    return {r, q};
  endfunction

  function automatic int ref_lat(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
    return (b == 32'd0) ? 2 : 33;
`else
    return 33;
`endif
  endfunction

  task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic scramble);
    logic [63:0] exp;
    int lat, got;
    exp = ref_div(sgn, a, b);
    lat = ref_lat(b);
    got = -1;
    signed_div = sgn; op1 = a; op2 = b; start = 1'b1;
    for (int e = 0; e <= 60; e++) begin
      tick();
      if (e == 0) chk({tag, " busy"}, 64'(busy), 64'd1);
      if (scramble && e == 1) begin
        op1 = $urandom; op2 = $urandom; signed_div = ~signed_div;
      end
      if (ready) begin
        got = e;
        break;
      end
    end
    chk({tag, " latency"}, 64'(got), 64'(lat));
    chk({tag, " result"}, result, exp);
    annul = 1'b1;
    tick();
    chk({tag, " hold"}, {63'd0, ready}, 64'd1);
    chk({tag, " hold result"}, result, exp);
    annul = 1'b0; start = 1'b0;
    tick();
    chk({tag, " drop"}, {result, 63'd0, ready}, 127'd0);
    chk({tag, " idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int saw_ready;
    logic        s;
    logic [31:0] a, b;

    repeat (3) tick();
    chk("reset result", result, 64'd0);
    chk("reset ready", 64'(ready), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    rst = 1'b0;
    tick();

    do_div("u100/7", 1'b0, 32'd100, 32'd7, 1'b0);
    chk("u100/7 model", ref_div(1'b0, 32'd100, 32'd7), 64'h0000_0002_0000_000E);
    do_div("s-7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
    chk("s-7/2 model", ref_div(1'b1, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
    do_div("smin/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_div("u7/0", 1'b0, 32'd7, 32'd0, 1'b0);
    do_div("s-7/0", 1'b1, 32'hFFFF_FFF9, 32'd0, 1'b0);
    do_div("ubig", 1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0);

    // Annul mid-divide, then restart two edges later
    saw_ready = 0;
    signed_div = 1'b0; op1 = 32'd1000; op2 = 32'd3; start = 1'b1;
    for (int e = 0; e < 10; e++) begin
      tick();
      if (ready) saw_ready++;
      if (e == 9) annul = 1'b1;
    end
    tick();
    annul = 1'b0; start = 1'b0;
    chk("annul busy", 64'(busy), 64'd0);
    chk("annul ready", 64'(ready | (saw_ready != 0)), 64'd0);
    tick();
    do_div("after annul 9/3", 1'b0, 32'd9, 32'd3, 1'b0);

    // Reset at E20 of an active divide
    signed_div = 1'b0; op1 = 32'd50000; op2 = 32'd13; start = 1'b1;
    for (int e = 0; e < 20; e++) begin
      tick();
      if (e == 19) rst = 1'b1;
    end
    tick();
    chk("rst mid result", result, 64'd0);
    chk("rst mid flags", {62'd0, ready, busy}, 64'd0);
    rst = 1'b0; start = 1'b0;
    tick();

    do_div("scramble", 1'b1, 32'hFFFF_0123, 32'd77, 1'b1);

    for (int i = 0; i < 24; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1, 2: b = 32'($urandom_range(1, 15));
        3: b = $urandom | 32'h8000_0000;
        default: b = $urandom;
      endcase
      do_div($sformatf("rand%0d", i), s, a, b, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
